// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller in front of the 32-bit single-cycle ALU.
// Latency: accepted instruction issues (alu_valid) the next cycle; ALU results write back at E+1, loads at E+2.
// Backpressure: in_ready drops for one cycle after a load (E) and for E and E+1 of a branch.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          decode-stage handshake; in_op/in_rs1/in_rs2/in_rd carry the instruction
//   alu_valid, alu_op          registered issue to the ALU (E cycle)
//   need_forward               {rs1_from_fwd, rs2_from_fwd} for the issued instruction
//   zero                       ALU compare result, sampled in E+1 of a branch
//   branch_resolved/_taken     single-cycle resolve pulse in E+1 of a branch
//   wb_en, wb_addr             register-file write strobe aligned to the forward bus
module alu_issue_ctrl #(
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [11:0]   in_op,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic [RW-1:0] in_rd,
    output logic          alu_valid,
    output logic [11:0]   alu_op,
    output logic [1:0]    need_forward,
    input  logic          zero,
    output logic          branch_resolved,
    output logic          branch_taken,
    output logic          wb_en,
    output logic [RW-1:0] wb_addr
);

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_S  = 7'b0100011;
    localparam logic [6:0] OPC_B  = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LD_WAIT,
        ST_BR_WAIT
    } state_t;

    state_t state_q;
    state_t state_d;

    // Decode of the instruction presented this cycle
    logic is_r, is_i, is_ld, is_s, is_b;
    logic reads_rs1, reads_rs2, is_alu_prod, is_issue;
    logic xfer;
    logic [1:0] nf_d;

    // Forward-bus tracking: fwd_rd_q is on the forward bus next cycle when fwd_vld_q
    logic          fwd_vld_q;
    logic [RW-1:0] fwd_rd_q;

    // Result pipeline: E-stage flags, then the extra load stage (E+1)
    logic          e_alu_wb_q;
    logic          e_ld_q;
    logic          e_br_q;
    logic [RW-1:0] e_rd_q;
    logic          m_ld_q;
    logic [RW-1:0] m_rd_q;

    always_comb begin
        is_r        = 1'b0;
        is_i        = 1'b0;
        is_ld       = 1'b0;
        is_s        = 1'b0;
        is_b        = 1'b0;
        unique case (in_op[6:0])
            OPC_R:   is_r  = 1'b1;
            OPC_I:   is_i  = 1'b1;
            OPC_LD:  is_ld = 1'b1;
            OPC_S:   is_s  = 1'b1;
            OPC_B:   is_b  = 1'b1;
            default: ;
        endcase
        reads_rs1   = is_r | is_i | is_ld | is_s | is_b;
        reads_rs2   = is_r | is_s | is_b;
        is_alu_prod = is_r | is_i;
        // Anything outside the five classes is a NOP: accepted, never issued
        is_issue    = reads_rs1;
    end

    assign nf_d[1] = fwd_vld_q && reads_rs1 && (in_rs1 == fwd_rd_q) && (in_rs1 != '0);
    assign nf_d[0] = fwd_vld_q && reads_rs2 && (in_rs2 == fwd_rd_q) && (in_rs2 != '0);

    // The resolve cycle (E+1 of a branch) also blocks issue so nothing
    // from the possibly-wrong path is accepted before the outcome is known.
    assign in_ready = !reset && (state_q == ST_RUN) && !branch_resolved;
    assign xfer     = in_valid && in_ready;

    assign branch_taken = branch_resolved && zero;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (xfer && is_ld) begin
                    state_d = ST_LD_WAIT;
                end else if (xfer && is_b) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_LD_WAIT: state_d = ST_RUN;
            ST_BR_WAIT: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_valid       <= 1'b0;
            alu_op          <= '0;
            need_forward    <= 2'b00;
            fwd_vld_q       <= 1'b0;
            fwd_rd_q        <= '0;
            e_alu_wb_q      <= 1'b0;
            e_ld_q          <= 1'b0;
            e_br_q          <= 1'b0;
            e_rd_q          <= '0;
            m_ld_q          <= 1'b0;
            m_rd_q          <= '0;
            wb_en           <= 1'b0;
            wb_addr         <= '0;
            branch_resolved <= 1'b0;
        end else begin
            alu_valid    <= xfer && is_issue;
            need_forward <= (xfer && is_issue) ? nf_d : 2'b00;
            if (xfer) begin
                alu_op <= in_op;
                e_rd_q <= in_rd;
            end

            // x0 results are dropped at the source so they never reach wb_en
            e_alu_wb_q <= xfer && is_alu_prod && (in_rd != '0);
            e_ld_q     <= xfer && is_ld && (in_rd != '0);
            e_br_q     <= xfer && is_b;

            // No transfer happens in LD_WAIT, so e_rd_q still holds the load rd
            m_ld_q <= e_ld_q;
            m_rd_q <= e_rd_q;

            // The load bubble guarantees these two sources never coincide
            wb_en   <= e_alu_wb_q || m_ld_q;
            wb_addr <= e_alu_wb_q ? e_rd_q : (m_ld_q ? m_rd_q : '0);

            branch_resolved <= e_br_q;

            // fwd_rd_q keeps the load rd through LD_WAIT; the load data lands
            // on the bus in E+2, i.e. the E of whatever is accepted next.
            if (state_q == ST_LD_WAIT) begin
                fwd_vld_q <= (fwd_rd_q != '0);
            end else if (xfer) begin
                fwd_rd_q  <= in_rd;
                fwd_vld_q <= is_alu_prod && (in_rd != '0);
            end else begin
                fwd_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instruction sequences push
// expected issue / writeback / branch events with their cycle; a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        alu_valid;
    logic [11:0] alu_op;
    logic [1:0]  need_forward;
    logic        zero;
    logic        branch_resolved;
    logic        branch_taken;
    logic        wb_en;
    logic [4:0]  wb_addr;

    alu_issue_ctrl #(.NREG(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rd           (in_rd),
        .alu_valid       (alu_valid),
        .alu_op          (alu_op),
        .need_forward    (need_forward),
        .zero            (zero),
        .branch_resolved (branch_resolved),
        .branch_taken    (branch_taken),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr)
    );

    // Instruction encodings: {5-bit funct, 7-bit opcode}
    localparam logic [11:0] OP_ADD  = 12'h033;
    localparam logic [11:0] OP_SUB  = 12'h833;
    localparam logic [11:0] OP_OR   = 12'h333;
    localparam logic [11:0] OP_ADDI = 12'h013;
    localparam logic [11:0] OP_LW   = 12'h103;
    localparam logic [11:0] OP_SW   = 12'h123;
    localparam logic [11:0] OP_BEQ  = 12'h063;
    localparam logic [11:0] OP_NOP  = 12'h00F;

    localparam int C_NOP = 0, C_ALU = 1, C_LD = 2, C_ST = 3, C_BR = 4;

    typedef struct { int cyc; logic [11:0] op; logic [1:0] nf; } iss_t;
    typedef struct { int cyc; logic [4:0] addr; } wb_t;
    typedef struct { int cyc; logic tk; } br_t;

    iss_t iss_q[$];
    wb_t  wb_q[$];
    br_t  br_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int st;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT event must match the oldest expectation of its kind
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_valid) begin
                if (iss_q.size() == 0) bad("issue_unexpected");
                else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("issue_cycle", cyc, e.cyc);
                    chk("alu_op", int'(alu_op), int'(e.op));
                    chk("need_forward", int'(need_forward), int'(e.nf));
                end
            end
            if (wb_en) begin
                if (wb_q.size() == 0) bad("wb_unexpected");
                else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_cycle", cyc, w.cyc);
                    chk("wb_addr", int'(wb_addr), int'(w.addr));
                end
            end
            if (branch_resolved) begin
                if (br_q.size() == 0) bad("branch_unexpected");
                else begin
                    br_t b;
                    b = br_q.pop_front();
                    chk("br_cycle", cyc, b.cyc);
                    chk("br_taken", int'(branch_taken), int'(b.tk));
                    chk("br_in_ready", int'(in_ready), 0);
                end
            end
        end
    end

    // Present one instruction, wait for acceptance, log expected events.
    // Returns at #1 after the transfer edge, i.e. at the start of its E cycle.
    task automatic send(input logic [11:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input int cls, input logic [1:0] nf,
                        input logic z, input bit push, output int stalls);
        int tc;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            bad("send_timeout");
            in_valid = 1'b0;
            return;
        end
        tc = cyc;
        if (push) begin
            if (cls != C_NOP) iss_q.push_back('{tc + 1, op, nf});
            if (cls == C_ALU && rd != 5'd0) wb_q.push_back('{tc + 2, rd});
            if (cls == C_LD  && rd != 5'd0) wb_q.push_back('{tc + 3, rd});
            if (cls == C_BR) br_q.push_back('{tc + 2, z});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (cls == C_BR) zero = z;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_alu_valid"}, int'(alu_valid), 0);
        chk({tag, "_alu_op"}, int'(alu_op), 0);
        chk({tag, "_need_forward"}, int'(need_forward), 0);
        chk({tag, "_wb_en"}, int'(wb_en), 0);
        chk({tag, "_wb_addr"}, int'(wb_addr), 0);
        chk({tag, "_branch_resolved"}, int'(branch_resolved), 0);
        chk({tag, "_branch_taken"}, int'(branch_taken), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        in_rd    = '0;
        zero     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Back-to-back dependency
        send(OP_ADD, 5'd1, 5'd2, 5'd5, C_ALU, 2'b00, 1'b0, 1, st);
        send(OP_SUB, 5'd5, 5'd5, 5'd6, C_ALU, 2'b11, 1'b0, 1, st);
        chk("b2b_stall", st, 0);
        idle(3);

        // Load-use: one bubble, addi E coincides with the load writeback.
        // rs2 field of addi is immediate bits equal to 7: must not forward.
        send(OP_LW,   5'd1, 5'd0, 5'd7, C_LD,  2'b00, 1'b0, 1, st);
        send(OP_ADDI, 5'd7, 5'd7, 5'd8, C_ALU, 2'b10, 1'b0, 1, st);
        chk("ld_use_stall", st, 1);
        idle(3);

        // x0 is neither forwarded nor written back
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, C_ALU, 2'b00, 1'b0, 1, st);
        send(OP_ADD,  5'd0, 5'd0, 5'd3, C_ALU, 2'b00, 1'b0, 1, st);
        idle(3);

        // Branches: taken then not taken; issue held through E and E+1
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, C_BR, 2'b00, 1'b1, 1, st);
        send(OP_BEQ, 5'd3, 5'd3, 5'd0, C_BR, 2'b00, 1'b0, 1, st);
        chk("branch_stall", st, 2);
        idle(3);

        // One idle cycle breaks forwarding
        send(OP_ADD, 5'd1, 5'd2, 5'd4, C_ALU, 2'b00, 1'b0, 1, st);
        idle(1);
        send(OP_OR,  5'd4, 5'd2, 5'd9, C_ALU, 2'b00, 1'b0, 1, st);
        idle(3);

        // Store reads both operands from the forward bus
        send(OP_ADD, 5'd1,  5'd2,  5'd10, C_ALU, 2'b00, 1'b0, 1, st);
        send(OP_SW,  5'd10, 5'd10, 5'd0,  C_ST,  2'b11, 1'b0, 1, st);
        idle(3);

        // A NOP transfer clears forwarding like any non-producer
        send(OP_ADD, 5'd1,  5'd2,  5'd11, C_ALU, 2'b00, 1'b0, 1, st);
        send(OP_NOP, 5'd11, 5'd11, 5'd0,  C_NOP, 2'b00, 1'b0, 1, st);
        chk("nop_stall", st, 0);
        send(OP_ADD, 5'd11, 5'd11, 5'd12, C_ALU, 2'b00, 1'b0, 1, st);
        idle(3);

        // Async reset during LD_WAIT: everything drops at once, load abandoned
        send(OP_LW, 5'd1, 5'd0, 5'd13, C_LD, 2'b00, 1'b0, 0, st);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", int'(in_ready), 1);
        @(posedge clk);
        #1;
        // No forwarding may survive the reset
        send(OP_ADD, 5'd13, 5'd13, 5'd14, C_ALU, 2'b00, 1'b0, 1, st);
        chk("post_reset_stall", st, 0);
        idle(5);

        chk("iss_q_drained", iss_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("br_q_drained", br_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/sequencing controller in front of the 32-bit single-cycle-latency ALU.
- Accepts decoded instructions from the decode stage over a valid/ready handshake and drives the ALU's `operation` and `need_forward` inputs.
- Inserts the mandatory bubble after loads and holds issue while a branch resolves.
- Generates register-file writeback enables timed to when each result appears on the forward bus.

Parameters:
- NREG, 32, number of architectural registers; register indices are 5 bits. Register x0 is never forwarded or written back.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  controller can accept this cycle.
- in_op  in  12  funct concatenated with the 7-bit opcode, in the ALU's operation format.
- in_rs1  in  5  source register 1 index.
- in_rs2  in  5  source register 2 index.
- in_rd  in  5  destination register index.
- alu_valid  out  1  ALU issue cycle ("E"); alu_op and need_forward are meaningful.
- alu_op  out  12  registered operation code to the ALU.
- need_forward  out  2  bit1 = rs1 taken from forward, bit0 = rs2 taken from forward (ALU encoding).
- zero  in  1  ALU branch compare result, valid in E+1 of a branch.
- branch_resolved  out  1  pulse in E+1 of a branch.
- branch_taken  out  1  equals zero while branch_resolved=1, else 0.
- wb_en  out  1  forward bus holds a result to be written this cycle.
- wb_addr  out  5  destination register for wb_en.

Behaviour:
- Classes by in_op[6:0]:
  - R 0110011: reads rs1, rs2; writes rd.
  - I 0010011: reads rs1; writes rd.
  - Load 0000011: reads rs1; writes rd.
  - S 0100011: reads rs1, rs2; no rd.
  - B 1100011: reads rs1, rs2; no rd.
  - Any other opcode is a NOP: accepted, alu_valid stays 0, no forwarding, no writeback.
- Handshake and issue timing:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - The instruction's E cycle is the following cycle: alu_valid=1 and alu_op/need_forward are registered.
  - alu_valid=0 in any cycle without a transfer on the previous edge.
- Forwarding:
  - Tracking registers: fwd_rd and fwd_vld, meaning "the forward bus in the next cycle carries fwd_rd".
  - need_forward[1] = fwd_vld && reads_rs1 && rs1==fwd_rd && rs1!=0.
  - need_forward[0] is computed the same way for rs2. For S-type, bit0 flags store-data forwarding; the ALU ignores it.
  - rs1==rs2==fwd_rd gives 2'b11.
- Result timing:
  - ALU producer issued in E: result on forward bus in E+1; wb_en=1, wb_addr=rd in E+1.
  - Load issued in E: data on forward bus in E+2; wb_en=1, wb_addr=rd in E+2.
  - Register file writes at the end of the wb_en cycle. Reads at the transfer cycle see only completed writes.
- FSM:
  - RUN:
    - in_ready=1.
    - On accepting a load, go to LD_WAIT.
    - On accepting a branch, go to BR_WAIT.
    - Otherwise stay in RUN.
  - LD_WAIT:
    - Lasts one cycle with in_ready=0, giving the mandatory bubble at E+1 of the load.
    - Sets fwd_rd=load rd and fwd_vld=(rd!=0) for the instruction accepted next.
    - Returns to RUN.
  - BR_WAIT:
    - Lasts one cycle with in_ready=0.
    - In E+1, branch_resolved=1 and branch_taken=zero.
    - fwd_vld=0; returns to RUN.
  - Accepting in RUN sets fwd_vld=(producer && rd!=0) and fwd_rd=rd.
  - An idle cycle (no transfer) clears fwd_vld.
- Reset (asynchronous, any state):
  - State returns to RUN; fwd_vld=0, fwd_rd=0.
  - Outputs: alu_valid=0, alu_op=0, need_forward=0, wb_en=0, wb_addr=0, branch_resolved=0, branch_taken=0.
  - in_ready=1 after reset deasserts.
  - A load or branch in flight is abandoned and no writeback fires.
- Simultaneous events:
  - A wb_en from a previous load and a new transfer in the same cycle are legal.
  - LD_WAIT guarantees that ALU and load results never share a forward-bus cycle.

Test Plan:
- Back-to-back dependency: `add x5,x1,x2` then `sub x6,x5,x5`. Second E has need_forward=2'b11. wb_en with wb_addr=5 occurs in first E+1.
- Load-use: `lw x7,0(x1)` then `addi x8,x7,4`. in_ready=0 for exactly one cycle. addi E = load E+2 with need_forward=2'b10. wb_addr=7 in that same cycle.
- x0 filter: `addi x0,x1,1` then `add x3,x0,x0` gives need_forward=2'b00 and no wb_en for the first instruction.
- Branch: `beq` with zero=1 in E+1 gives branch_resolved=1, branch_taken=1, in_ready=0 that cycle. With zero=0, branch_taken=0. Neither case produces wb_en.
- Gap breaks forwarding: `add x4,...`, one idle cycle, then `or x9,x4,x2` gives need_forward=2'b00.
- Reset during LD_WAIT (async, mid-cycle): all outputs go to 0 immediately. No wb_en for the load. in_ready=1 on the first cycle after release.
